// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: FSM states,
// fixed header words, tuser field layout and the port-selection LFSR.
package axis_pkt_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    // Header beats occupy the low 64 bits of tdata; wider buses are zero-filled.
    localparam logic [63:0] HDR0_WORD = 64'hEFBEFECAFECAFECA;
    localparam logic [63:0] HDR1_WORD = 64'h00000008EFBEEFBE;

    // tuser layout: byte length, one-hot source port, destination port (unused, zero).
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_W   = 16;
    localparam int TUSER_SRC_LSB = 16;
    localparam int TUSER_SRC_W   = 8;
    localparam int TUSER_DST_LSB = 24;
    localparam int TUSER_DST_W   = 8;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One LFSR step: shift left, feed back the XOR of the tapped bits.
    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_pkt_gen_lfsr.sv
// Pseudo-random source for port selection; steps once per advance pulse.
module axis_pkt_gen_lfsr
    import axis_pkt_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        adv_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value: step only when a packet is starting, otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = lfsrNext(lfsr_q);
        end
    end

    // State register, returns to the seed on reset so sequences are repeatable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream test packet generator: two header beats, an incrementing-byte
// payload and a configurable idle gap, repeated per run with port tagging.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_USER_WIDTH      = 128,
    parameter int C_NUM_PORTS       = 5,
    parameter int C_PAYLOAD_WORDS   = 32,
    parameter int C_GAP_CYCLES      = 128,
    parameter int C_PORT_MODE       = 0
) (
    input  logic                           axi_aclk,
    input  logic                           axi_resetn,
    input  logic                           start,
    input  logic [15:0]                    pkt_limit,
    input  logic                           stop,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           busy,
    output logic [15:0]                    pkt_sent
);

    localparam int          STRB_W      = C_AXIS_DATA_WIDTH / 8;
    localparam logic [15:0] PKT_LEN     = 16'((C_PAYLOAD_WORDS + 2) * STRB_W);
    localparam logic [7:0]  LAST_BEAT   = 8'(C_PAYLOAD_WORDS - 1);
    localparam logic [7:0]  LAST_GAP    = 8'(C_GAP_CYCLES - 1);
    localparam logic [2:0]  LAST_PORT   = 3'(C_NUM_PORTS - 1);
    localparam logic [31:0] NUM_PORTS_U = 32'(C_NUM_PORTS);

    state_e                        state_q;
    logic [7:0]                    beat_q;
    logic [7:0]                    gap_q;
    logic [2:0]                    port_q;
    logic                          stop_q;
    logic                          busy_q;
    logic                          tvalid_q;
    logic                          tlast_q;
    logic [15:0]                   pktSent_q;
    logic [C_AXIS_DATA_WIDTH-1:0]  tdata_q;
    logic [C_USER_WIDTH-1:0]       tuser_q;

    logic [15:0] lfsrValue;
    logic        lfsrAdv_d;
    logic        xfer_d;
    logic        lastXfer_d;
    logic        stopSeen_d;
    logic        gapDone_d;
    logic        runDoneGap_d;
    logic        runDoneNoGap_d;
    logic        firstStart_d;
    logic        nextStart_d;
    logic [7:0]  beatNext_d;
    logic [15:0] pktSentInc_d;
    logic [2:0]  lfsrPort_d;
    logic [2:0]  startPort_d;

    // Header word zero-extended to the bus width.
    function automatic logic [C_AXIS_DATA_WIDTH-1:0] hdrWord(input logic [63:0] w);
        logic [C_AXIS_DATA_WIDTH-1:0] r;
        r       = '0;
        r[63:0] = w;
        return r;
    endfunction

    // Payload beat k carries k in every byte lane.
    function automatic logic [C_AXIS_DATA_WIDTH-1:0] payloadWord(input logic [7:0] k);
        return {STRB_W{k}};
    endfunction

    // Packet metadata: byte length plus one-hot source port, everything else zero.
    function automatic logic [C_USER_WIDTH-1:0] userWord(input logic [2:0] port);
        logic [C_USER_WIDTH-1:0] r;
        r = '0;
        r[TUSER_LEN_LSB +: TUSER_LEN_W] = PKT_LEN;
        r[TUSER_SRC_LSB +: TUSER_SRC_W] = 8'd1 << port;
        return r;
    endfunction

    axis_pkt_gen_lfsr u_lfsr (
        .clk_i   (axi_aclk),
        .rst_ni  (axi_resetn),
        .adv_i   (lfsrAdv_d),
        .value_o (lfsrValue)
    );

    // Transfer detection, run-termination decisions and next-port selection.
    always_comb begin
        xfer_d         = tvalid_q & m_axis_tready;
        lastXfer_d     = xfer_d & tlast_q & (state_q == ST_PAYLOAD);
        stopSeen_d     = stop_q | stop;
        beatNext_d     = beat_q + 8'd1;
        pktSentInc_d   = (pktSent_q == 16'hFFFF) ? pktSent_q : pktSent_q + 16'd1;
        gapDone_d      = (state_q == ST_GAP) && (gap_q == LAST_GAP);
        runDoneGap_d   = stopSeen_d || ((pkt_limit != 16'd0) && (pktSent_q == pkt_limit));
        runDoneNoGap_d = stopSeen_d || ((pkt_limit != 16'd0) && (pktSentInc_d == pkt_limit));
        firstStart_d   = (state_q == ST_IDLE) && start;
        nextStart_d    = (gapDone_d && !runDoneGap_d) ||
                         (lastXfer_d && (C_GAP_CYCLES == 0) && !runDoneNoGap_d);
        lfsrAdv_d      = firstStart_d || nextStart_d;
        lfsrPort_d     = 3'({16'd0, lfsrValue} % NUM_PORTS_U);
        startPort_d    = 3'd0;
        if (C_PORT_MODE != 0) begin
            startPort_d = lfsrPort_d;
        end else if (nextStart_d && (port_q != LAST_PORT)) begin
            startPort_d = port_q + 3'd1;
        end
    end

    // Main FSM with registered stream outputs; outputs change only on a
    // transfer or a state change so they stay stable under backpressure.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            gap_q     <= '0;
            port_q    <= '0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            pktSent_q <= '0;
            tdata_q   <= '0;
            tuser_q   <= '0;
        end else if (firstStart_d || nextStart_d) begin
            state_q  <= ST_HDR0;
            port_q   <= startPort_d;
            stop_q   <= stop;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            beat_q   <= '0;
            gap_q    <= '0;
            tdata_q  <= hdrWord(HDR0_WORD);
            tuser_q  <= userWord(startPort_d);
            if (firstStart_d) begin
                pktSent_q <= '0;
            end else if (lastXfer_d) begin
                pktSent_q <= pktSentInc_d;
            end
        end else begin
            stop_q <= stopSeen_d;
            case (state_q)
                ST_IDLE: begin
                    stop_q <= 1'b0;
                end
                ST_HDR0: begin
                    if (xfer_d) begin
                        state_q <= ST_HDR1;
                        tdata_q <= hdrWord(HDR1_WORD);
                    end
                end
                ST_HDR1: begin
                    if (xfer_d) begin
                        state_q <= ST_PAYLOAD;
                        beat_q  <= '0;
                        tdata_q <= payloadWord(8'd0);
                        tlast_q <= (LAST_BEAT == 8'd0);
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer_d) begin
                        if (tlast_q) begin
                            pktSent_q <= pktSentInc_d;
                            tvalid_q  <= 1'b0;
                            tlast_q   <= 1'b0;
                            tdata_q   <= '0;
                            tuser_q   <= '0;
                            if (C_GAP_CYCLES != 0) begin
                                state_q <= ST_GAP;
                                gap_q   <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                stop_q  <= 1'b0;
                            end
                        end else begin
                            beat_q  <= beatNext_d;
                            tdata_q <= payloadWord(beatNext_d);
                            tlast_q <= (beatNext_d == LAST_BEAT);
                        end
                    end
                end
                ST_GAP: begin
                    if (gapDone_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        stop_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = '1;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign pkt_sent      = pktSent_q;

endmodule
